// File: rtl/min_max_pkg.sv
// Shared encodings for the min/max bar-graph LED driver: mode commands and
// fault-injection selectors.
package min_max_pkg;

    typedef enum logic [1:0] {
        COM_WINDOW = 2'b00,
        COM_THERMO = 2'b01,
        COM_OFF    = 2'b10,
        COM_ON     = 2'b11
    } com_e;

    localparam int ERR_NONE       = 0;
    localparam int ERR_NO_MAX     = 1;
    localparam int ERR_NO_BLINK   = 2;
    localparam int ERR_SWAP_FORCE = 3;

endpackage : min_max_pkg

// File: rtl/min_max_decode.sv
// Combinational LED pattern decoder: builds the next LED vector bit by bit
// from per-LED comparisons against min, val and max.
module min_max_decode
    import min_max_pkg::*;
#(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic [1:0]            com_i,
    input  logic [VALSIZE-1:0]    min_i,
    input  logic [VALSIZE-1:0]    max_i,
    input  logic [VALSIZE-1:0]    val_i,
    input  logic                  osc_i,
    output logic [2**VALSIZE-1:0] leds_o
);

    localparam int NLEDS = 2**VALSIZE;

    logic                 w_in_range;
    logic                 w_blink;
    logic [NLEDS-1:0]     w_window;
    logic [NLEDS-1:0]     w_thermo;
    logic [NLEDS-1:0]     w_off;
    logic [NLEDS-1:0]     w_on;

    // A value above max is normally out of window; the ERR_NO_MAX mutant drops that check.
    assign w_in_range = (ERRNO == ERR_NO_MAX) ? (min_i <= val_i)
                                              : ((min_i <= val_i) && (val_i <= max_i));
    assign w_blink    = (ERRNO == ERR_NO_BLINK) ? 1'b0 : osc_i;

    for (genvar i = 0; i < NLEDS; i++) begin : g_led
        localparam logic [VALSIZE-1:0] IDX = VALSIZE'(i);
        logic w_ge_min;
        logic w_le_val;
        logic w_le_max;

        assign w_ge_min    = (IDX >= min_i);
        assign w_le_val    = (IDX <= val_i);
        assign w_le_max    = (IDX <= max_i);
        assign w_window[i] = w_in_range & w_ge_min & (w_le_val | (w_le_max & w_blink));
        assign w_thermo[i] = w_le_val;
    end

    assign w_off = (ERRNO == ERR_SWAP_FORCE) ? '1 : '0;
    assign w_on  = (ERRNO == ERR_SWAP_FORCE) ? '0 : '1;

    // Conditional operators (not a case) so an unknown com_i merges to X instead of
    // falling into a default branch.
    assign leds_o = (com_i == COM_WINDOW) ? w_window :
                    (com_i == COM_THERMO) ? w_thermo :
                    (com_i == COM_OFF)    ? w_off    : w_on;

endmodule : min_max_decode

// File: rtl/min_max_display.sv
// Bar-graph LED driver top: decoder followed by one registered LED bank with
// asynchronous active-high clear.
module min_max_display
    import min_max_pkg::*;
#(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            com_i,
    input  logic [VALSIZE-1:0]    max_i,
    input  logic [VALSIZE-1:0]    min_i,
    input  logic                  osc_i,
    input  logic [VALSIZE-1:0]    val_i,
    output logic [2**VALSIZE-1:0] leds_o
);

    logic [2**VALSIZE-1:0] w_next;
    logic [2**VALSIZE-1:0] r_leds;

    min_max_decode #(
        .VALSIZE (VALSIZE),
        .ERRNO   (ERRNO)
    ) u_decode (
        .com_i  (com_i),
        .min_i  (min_i),
        .max_i  (max_i),
        .val_i  (val_i),
        .osc_i  (osc_i),
        .leds_o (w_next)
    );

    // NOTE: reset sits in the sensitivity list so the LEDs clear without a clock edge;
    // non-blocking assignment keeps every register sampling pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_next;
        end
    end

    assign leds_o = r_leds;

endmodule : min_max_display

// File: tb/tb_min_max_display.sv
// Self-checking bench for min_max_display: directed test-plan steps followed by
// random stimulus compared against a per-LED behavioural model.
module tb_min_max_display;

    localparam int VALSIZE = 4;
    localparam int NLEDS   = 2**VALSIZE;

    logic               clk;
    logic               rst;
    logic [1:0]         com;
    logic [VALSIZE-1:0] mn;
    logic [VALSIZE-1:0] mx;
    logic [VALSIZE-1:0] val;
    logic               osc;
    logic [NLEDS-1:0]   leds;

    int checks = 0;
    int errors = 0;

    min_max_display #(
        .VALSIZE (VALSIZE),
        .ERRNO   (0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .com_i  (com),
        .max_i  (mx),
        .min_i  (mn),
        .osc_i  (osc),
        .val_i  (val),
        .leds_o (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk every LED index and apply the display rules directly.
    function automatic logic [NLEDS-1:0] model(input logic [1:0] c, input int lo,
                                               input int hi, input int v, input logic o);
        logic [NLEDS-1:0] l;
        l = '0;
        case (c)
            2'b00: if (lo <= v && v <= hi)
                       for (int i = 0; i < NLEDS; i++)
                           if (i >= lo && i <= v)      l[i] = 1'b1;
                           else if (i > v && i <= hi)  l[i] = o;
            2'b01: for (int i = 0; i < NLEDS; i++) l[i] = (i <= v);
            2'b10: l = '0;
            default: l = '1;
        endcase
        return l;
    endfunction

    task automatic check(input string tag, input logic [NLEDS-1:0] got,
                         input logic [NLEDS-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive away from the edge, let one rising edge capture, sample 1 ns later.
    task automatic apply(input logic [1:0] c, input int lo, input int hi,
                         input int v, input logic o);
        @(negedge clk);
        com = c;
        mn  = VALSIZE'(lo);
        mx  = VALSIZE'(hi);
        val = VALSIZE'(v);
        osc = o;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [1:0] c, input int lo,
                        input int hi, input int v, input logic o,
                        input logic [NLEDS-1:0] exp);
        apply(c, lo, hi, v, o);
        check(tag, leds, exp);
        check({tag, "_model"}, leds, model(c, lo, hi, v, o));
    endtask

    initial begin
        rst = 1'b1;
        com = 2'b11;
        mn  = '0;
        mx  = '0;
        val = '0;
        osc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", leds, '0);
        @(negedge clk);
        rst = 1'b0;

        step("win_blink_hi",  2'b00, 3, 12, 8, 1'b1, 16'h1FF8);
        step("win_blink_lo",  2'b00, 3, 12, 8, 1'b0, 16'h01F8);
        step("win_above_max", 2'b00, 3, 12, 13, 1'b1, 16'h0000);
        step("win_below_min", 2'b00, 3, 12, 2, 1'b1, 16'h0000);
        step("win_min_gt_max",2'b00, 10, 5, 7, 1'b1, 16'h0000);
        step("win_single",    2'b00, 6, 6, 6, 1'b1, 16'h0040);
        step("win_full",      2'b00, 0, 15, 15, 1'b1, 16'hFFFF);
        step("win_val_eq_max",2'b00, 2, 9, 9, 1'b1, 16'h03FC);
        step("thermo_5",      2'b01, 9, 2, 5, 1'b1, 16'h003F);
        step("thermo_0",      2'b01, 0, 0, 0, 1'b0, 16'h0001);
        step("thermo_15",     2'b01, 3, 4, 15, 1'b0, 16'hFFFF);
        step("force_off",     2'b10, 0, 15, 7, 1'b1, 16'h0000);
        step("force_on",      2'b11, 0, 0, 0, 1'b0, 16'hFFFF);

        // Asynchronous reset mid-cycle while all LEDs are lit.
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", leds, '0);
        @(posedge clk);
        #1;
        check("rst_held", leds, '0);
        @(negedge clk);
        rst = 1'b0;
        com = 2'b01;
        val = 4'd3;
        #1;
        check("rst_release_no_edge", leds, '0);
        @(posedge clk);
        #1;
        check("rst_first_capture", leds, 16'h000F);

        // Random sweep; inputs change every cycle.
        for (int n = 0; n < 300; n++) begin
            logic [1:0] c;
            int lo, hi, v;
            logic o;
            c  = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) != 0) c = 2'b00;
            lo = int'($urandom_range(NLEDS - 1, 0));
            hi = int'($urandom_range(NLEDS - 1, 0));
            v  = int'($urandom_range(NLEDS - 1, 0));
            o  = 1'($urandom_range(1, 0));
            apply(c, lo, hi, v, o);
            check($sformatf("rand_%0d", n), leds, model(c, lo, hi, v, o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_min_max_display
